// File: rtl/ft6336_pkg.sv
// FT6336G register-map constants and touch register types shared by the I2C target and the polling driver.
// Latency: n/a (constants, types and a combinational read mux only).
// Backpressure: n/a.
package ft6336_pkg;

  localparam logic [6:0] FT6336_DEFAULT_ADDR = 7'h38;

  localparam logic [7:0] REG_DEV_MODE  = 8'h00;
  localparam logic [7:0] REG_TD_STATUS = 8'h02;
  localparam logic [7:0] REG_P1_XH     = 8'h03;
  localparam logic [7:0] REG_P1_XL     = 8'h04;
  localparam logic [7:0] REG_P1_YH     = 8'h05;
  localparam logic [7:0] REG_P1_YL     = 8'h06;
  localparam logic [7:0] REG_CHIP_ID   = 8'hA3;

  // Event flag carried in P1_XH[7:6]
  localparam logic [1:0] EVT_CONTACT = 2'b10;
  localparam logic [1:0] EVT_LIFT    = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ACK_ADDR_W, ST_ACK_ADDR_R, ST_REG_PTR, ST_ACK_PTR,
    ST_WR_DATA, ST_ACK_WR, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } i2c_state_t;

  typedef struct packed {
    logic [7:0]  dev_mode;
    logic        down;
    logic [11:0] x;
    logic [11:0] y;
  } touch_regs_t;

  // Register map as seen by a reading controller.
  function automatic logic [7:0] reg_read(input touch_regs_t r, input logic [7:0] addr,
                                          input logic [7:0] chip_id);
    case (addr)
      REG_DEV_MODE:  return r.dev_mode;
      REG_TD_STATUS: return {7'b0, r.down};
      REG_P1_XH:     return {(r.down ? EVT_CONTACT : EVT_LIFT), 2'b00, r.x[11:8]};
      REG_P1_XL:     return r.x[7:0];
      REG_P1_YH:     return {4'b0, r.y[11:8]};
      REG_P1_YL:     return r.y[7:0];
      REG_CHIP_ID:   return chip_id;
      default:       return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
`timescale 1ns/1ps
// Synchronizes one raw I2C pad line, rejects glitches shorter than FILTER_LEN samples, and flags edges.
// Latency: 2 sync stages + FILTER_LEN samples + 1 register (about 6 clk at FILTER_LEN=3).
// Backpressure: none; rise/fall are single-cycle events aligned with the level update.
// Ports: clk, reset_n (async active-low), line_in (raw pad), level (filtered), rise/fall (edge strobes).
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;

  // Idle bus level is high, so everything resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      hist <= {hist[FILTER_LEN-2:0], sync[1]};
      rise <= 1'b0;
      fall <= 1'b0;
      if (&hist && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (!(|hist) && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft6336_i2c_target.sv
`timescale 1ns/1ps
// I2C target emulating the FT6336G touch controller register interface (optional interrupt: FT_TARGET_INT_EN).
// Latency: bus events act about 6 clk after the pad edge; snapshot taken on the read-address 8th SCL rise.
// Backpressure: none; no clock stretching, SCL is input only. sda_oe changes only on filtered SCL fall.
// Ports: clk, reset_n, scl_in/sda_in (raw pads), sda_oe (1 = pull SDA low), touch_update/down/x/y
//        (sample strobe + data), bus_busy, rd_done (read NACKed), ctp_int (active-low interrupt).
module ft6336_i2c_target
  import ft6336_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR         = FT6336_DEFAULT_ADDR,
  parameter int         FILTER_LEN       = 3,
  parameter logic [7:0] CHIP_ID          = 8'h64,
  parameter int         INT_PULSE_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        touch_update,
  input  logic        touch_down,
  input  logic [11:0] touch_x,
  input  logic [11:0] touch_y,
  output logic        bus_busy,
  output logic        rd_done,
  output logic        ctp_int
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .reset_n(reset_n), .line_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .reset_n(reset_n), .line_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_t  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  reg_ptr;
  touch_regs_t live;
  touch_regs_t snap;

  logic       start_cond, stop_cond;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign byte_in    = {shreg[6:0], sda_lvl};
  assign rd_byte    = reg_read(snap, reg_ptr, CHIP_ID);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      reg_ptr  <= '0;
      live     <= '0;
      snap     <= '0;
      sda_oe   <= 1'b0;
      bus_busy <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (touch_update) begin
        live.down <= touch_down;
        live.x    <= touch_x;
        live.y    <= touch_y;
      end

      if (start_cond) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        bus_busy <= 1'b1;
        sda_oe   <= 1'b0;
      end else if (stop_cond) begin
        state    <= ST_IDLE;
        bus_busy <= 1'b0;
        sda_oe   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (byte_in[7:1] != I2C_ADDR) begin
                state <= ST_IGNORE;
              end else if (byte_in[0]) begin
                // A sample arriving in the capture cycle wins, so the read never returns stale data.
                snap.dev_mode <= live.dev_mode;
                snap.down     <= touch_update ? touch_down : live.down;
                snap.x        <= touch_update ? touch_x    : live.x;
                snap.y        <= touch_update ? touch_y    : live.y;
                state         <= ST_ACK_ADDR_R;
              end else begin
                state <= ST_ACK_ADDR_W;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          ST_REG_PTR, ST_WR_DATA: if (scl_rise) begin
            shreg <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (state == ST_REG_PTR) begin
                reg_ptr <= byte_in;
                state   <= ST_ACK_PTR;
              end else begin
                if (reg_ptr == REG_DEV_MODE) live.dev_mode <= byte_in;
                reg_ptr <= reg_ptr + 8'd1;
                state   <= ST_ACK_WR;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // bit_cnt 0: waiting for the fall that ends the 8th bit; 1: ACK is being driven.
          ST_ACK_ADDR_W, ST_ACK_ADDR_R, ST_ACK_PTR, ST_ACK_WR: if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe  <= 1'b1;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= '0;
              if (state == ST_ACK_ADDR_R) begin
                sda_oe <= ~rd_byte[7];
                shreg  <= {rd_byte[6:0], 1'b0};
                state  <= ST_RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ST_ACK_ADDR_W) ? ST_REG_PTR : ST_WR_DATA;
              end
            end
          end

          // bit_cnt counts SCL rises of the byte being sent; MSB is already on the bus on entry.
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                reg_ptr <= reg_ptr + 8'd1;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl) begin
                rd_done <= 1'b1;
                state   <= ST_IGNORE;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              sda_oe  <= ~rd_byte[7];
              shreg   <= {rd_byte[6:0], 1'b0};
              state   <= ST_RD_DATA;
            end
          end

          default: ;  // IDLE and IGNORE only react to START/STOP
        endcase
      end
    end
  end

`ifdef FT_TARGET_INT_EN
  localparam int INT_W = $clog2(INT_PULSE_CYCLES + 1);
  logic [INT_W-1:0] int_cnt;

  // Low for exactly INT_PULSE_CYCLES cycles; a new contact sample restarts the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_cnt <= '0;
      ctp_int <= 1'b1;
    end else if (touch_update && touch_down) begin
      int_cnt <= INT_W'(INT_PULSE_CYCLES - 1);
      ctp_int <= 1'b0;
    end else if (int_cnt != '0) begin
      int_cnt <= int_cnt - INT_W'(1);
    end else begin
      ctp_int <= 1'b1;
    end
  end
`else
  // Interrupt compiled out: pin is idle-high whatever the pulse length is set to.
  assign ctp_int = 1'b1 | (INT_PULSE_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ft6336_i2c_target.sv
`timescale 1ns/1ps
module tb_ft6336_i2c_target;

  localparam int H = 25;  // SCL half period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        touch_update = 1'b0;
  logic        touch_down = 1'b0;
  logic [11:0] touch_x = '0;
  logic [11:0] touch_y = '0;
  logic        scl_in, sda_in, sda_oe, bus_busy, rd_done, ctp_int;

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int bb_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] rd_buf [8];

  // Open-drain wired-AND of master and target
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  ft6336_i2c_target dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .touch_update(touch_update), .touch_down(touch_down), .touch_x(touch_x), .touch_y(touch_y),
    .bus_busy(bus_busy), .rd_done(rd_done), .ctp_int(ctp_int)
  );

  always @(negedge clk) begin
    if (sda_oe === 1'b1)   oe_cnt++;
    if (bus_busy === 1'b1) bb_cnt++;
    if (rd_done === 1'b1)  rd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic i2c_write(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(H);
      scl_m = 1'b1; tick(H);
      scl_m = 1'b0; tick(4);
    end
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H / 2);
    ack = sda_in; tick(H - H / 2);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic i2c_read(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(H);
      scl_m = 1'b1; tick(H / 2);
      d[i] = sda_in; tick(H - H / 2);
      scl_m = 1'b0; tick(4);
    end
    sda_m = nack; tick(H);
    scl_m = 1'b1; tick(H);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic update_sample(input logic d, input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    touch_down = d; touch_x = x; touch_y = y; touch_update = 1'b1;
    @(negedge clk);
    touch_update = 1'b0;
  endtask

  // START, write address, pointer byte; no STOP so a repeated START can follow.
  task automatic set_ptr(input logic [7:0] p, output logic nak);
    logic a1, a2;
    i2c_start();
    i2c_write(8'h70, a1);
    i2c_write(p, a2);
    nak = a1 | a2;
  endtask

  // (Repeated) START, read n bytes NACKing the last, STOP. Optional touch update after byte upd_after.
  task automatic read_txn(input int n, input int upd_after, input logic [11:0] upd_x, output logic nak);
    logic a;
    i2c_start();
    i2c_write(8'h71, a);
    nak = a;
    for (int i = 0; i < n; i++) begin
      i2c_read(i == n - 1, rd_buf[i]);
      if (i == upd_after) update_sample(1'b1, upd_x, 12'h1E0);
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    tick(5);
    checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_bus_busy: got %b expected 0", bus_busy); end
    checks++; if (rd_done !== 1'b0)  begin errors++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
    checks++; if (ctp_int !== 1'b1)  begin errors++; $display("FAIL reset_ctp_int: got %b expected 1", ctp_int); end
    reset_n = 1'b1;
    tick(10);
  endtask

  task automatic test_addr_mismatch();
    logic a, nak;
    int oe0, bb0;
    update_sample(1'b1, 12'h123, 12'h1E0);
    oe0 = oe_cnt; bb0 = bb_cnt;
    i2c_start();
    i2c_write(8'h72, a);
    i2c_write(8'h02, nak);
    i2c_stop();
    tick(10);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL mismatch_nack: got %b expected 1", a); end
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL mismatch_no_drive: got %0d drive cycles expected 0", oe_cnt - oe0); end
    checks++; if (bb_cnt <= bb0) begin errors++; $display("FAIL mismatch_busy_pulse: got %0d busy cycles expected >0", bb_cnt - bb0); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy_end: got %b expected 0", bus_busy); end
    // Pointer must still be 0x00 (DEV_MODE = 0), not 0x02 (TD_STATUS = 1)
    read_txn(1, -1, 12'h0, nak);
    checks++; if (nak !== 1'b0) begin errors++; $display("FAIL mismatch_read_ack: got %b expected 0", nak); end
    checks++; if (rd_buf[0] !== 8'h00) begin errors++; $display("FAIL mismatch_ptr_kept: got %h expected 00", rd_buf[0]); end
  endtask

  task automatic test_read_sample(input logic down, input logic [7:0] exp_st, input logic [7:0] exp_xh);
    logic nak1, nak2;
    int rd0;
    logic [7:0] exp [5];
    exp = '{exp_st, exp_xh, 8'h23, 8'h01, 8'hE0};
    update_sample(down, 12'h123, 12'h1E0);
    rd0 = rd_cnt;
    set_ptr(8'h02, nak1);
    read_txn(5, -1, 12'h0, nak2);
    tick(10);
    checks++; if ((nak1 | nak2) !== 1'b0) begin errors++; $display("FAIL read%0d_acks: got %b expected 0", down, nak1 | nak2); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL read%0d_byte%0d: got %h expected %h", down, i, rd_buf[i], exp[i]); end
    end
    checks++; if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL read%0d_rd_done: got %0d pulses expected 1", down, rd_cnt - rd0); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL read%0d_busy_end: got %b expected 0", down, bus_busy); end
  endtask

  task automatic test_chip_id_wrap();
    logic a1, a2, a3, nak;
    i2c_start();
    i2c_write(8'h70, a1);
    i2c_write(8'h00, a2);
    i2c_write(8'h5A, a3);
    i2c_stop();
    checks++; if ((a1 | a2 | a3) !== 1'b0) begin errors++; $display("FAIL devmode_write_acks: got %b expected 0", a1 | a2 | a3); end
    set_ptr(8'hA3, nak);
    read_txn(1, -1, 12'h0, nak);
    checks++; if (rd_buf[0] !== 8'h64) begin errors++; $display("FAIL chip_id: got %h expected 64", rd_buf[0]); end
    set_ptr(8'hFF, nak);
    read_txn(2, -1, 12'h0, nak);
    checks++; if (rd_buf[0] !== 8'h00) begin errors++; $display("FAIL wrap_ff: got %h expected 00", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h5A) begin errors++; $display("FAIL wrap_dev_mode: got %h expected 5a", rd_buf[1]); end
  endtask

  task automatic test_coherency();
    logic nak;
    logic [7:0] exp [5];
    exp = '{8'h01, 8'h81, 8'h23, 8'h01, 8'hE0};
    update_sample(1'b1, 12'h123, 12'h1E0);
    set_ptr(8'h02, nak);
    read_txn(5, 1, 12'h200, nak);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL coherent_byte%0d: got %h expected %h", i, rd_buf[i], exp[i]); end
    end
    set_ptr(8'h03, nak);
    read_txn(2, -1, 12'h0, nak);
    checks++; if (rd_buf[0] !== 8'h82) begin errors++; $display("FAIL new_sample_xh: got %h expected 82", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h00) begin errors++; $display("FAIL new_sample_xl: got %h expected 00", rd_buf[1]); end
  endtask

  task automatic test_reset_mid_read();
    logic a, nak;
    set_ptr(8'h02, nak);
    i2c_start();
    i2c_write(8'h71, a);
    sda_m = 1'b1;
    tick(20);
    // First byte is TD_STATUS = 0x01, so its MSB (0) is being driven
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_driving: got %b expected 1", sda_oe); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL async_reset_release: got %b expected 0", sda_oe); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", bus_busy); end
    scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    reset_n = 1'b1;
    tick(20);
    checks++; if (bus_busy !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b oe=%b expected 0 0", bus_busy, sda_oe); end
    update_sample(1'b1, 12'h123, 12'h1E0);
    set_ptr(8'h03, nak);
    read_txn(2, -1, 12'h0, a);
    checks++; if ((nak | a) !== 1'b0) begin errors++; $display("FAIL post_reset_acks: got %b expected 0", nak | a); end
    checks++; if (rd_buf[0] !== 8'h81) begin errors++; $display("FAIL post_reset_xh: got %h expected 81", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h23) begin errors++; $display("FAIL post_reset_xl: got %h expected 23", rd_buf[1]); end
  endtask

  initial begin
    test_reset();
    test_addr_mismatch();
    test_read_sample(1'b1, 8'h01, 8'h81);
    test_read_sample(1'b0, 8'h00, 8'h41);
    test_chip_id_wrap();
    test_coherency();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
